// File: rtl/mult_datapath.sv
// Datapath for the sequential shift-add multiplier: multiplicand, {carry, product}
// register and iteration counter, driven by the control FSM's strobes.
module mult_datapath #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 CLK,
   input  logic                 reset_n,
   input  logic [WIDTH-1:0]     mcand,
   input  logic [WIDTH-1:0]     mplier,
   input  logic                 i_clr,
   input  logic                 write,
   input  logic                 shiftR,
   input  logic                 i_incr,
   output logic                 p0,
   output logic                 i_lt_32,
   output logic [2*WIDTH-1:0]   product,
   output logic                 product_valid
);

   localparam logic [CNT_W:0] WIDTH_C = (CNT_W+1)'(WIDTH);

   logic [WIDTH-1:0]   mc_q, mc_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               valid_q, valid_d;
   logic [WIDTH:0]     sum;
   logic [CNT_W:0]     cnt_p1;

   // Compare one bit wider so cnt+1 cannot wrap when the counter saturates.
   assign cnt_p1        = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign i_lt_32       = (cnt_p1 < WIDTH_C);
   assign p0            = prod_q[0];
   assign product       = prod_q;
   assign product_valid = valid_q;
   assign sum           = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mc_q};

   always_comb begin
      mc_d    = mc_q;
      prod_d  = prod_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (i_clr) begin
         mc_d    = mcand;
         prod_d  = {{WIDTH{1'b0}}, mplier};
         carry_d = 1'b0;
         cnt_d   = '0;
         valid_d = 1'b0;
      end else begin
         // write beats shiftR; the FSM never issues both together.
         if (write) begin
            {carry_d, prod_d[2*WIDTH-1:WIDTH]} = sum;
         end else if (shiftR) begin
            prod_d  = {carry_q, prod_q[2*WIDTH-1:1]};
            carry_d = 1'b0;
            if (!i_lt_32) valid_d = 1'b1;
         end
         if (i_incr && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_p1[CNT_W-1:0];
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         mc_q    <= '0;
         prod_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         mc_q    <= mc_d;
         prod_q  <= prod_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_mult_datapath.sv
// Randomized scoreboard bench for mult_datapath: a driver plays the control FSM,
// a monitor checks every completed product against plain a*b.
module tb_mult_datapath;

   logic        CLK = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] mcand = '0, mplier = '0;
   logic        i_clr = 1'b0, write = 1'b0, shiftR = 1'b0, i_incr = 1'b0;
   logic        p0, i_lt_32, product_valid;
   logic [63:0] product;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   logic        vld_prev = 1'b0;
   logic        done = 1'b0;

   mult_datapath #(.WIDTH(32), .CNT_W(6)) dut (
      .CLK(CLK), .reset_n(reset_n), .mcand(mcand), .mplier(mplier),
      .i_clr(i_clr), .write(write), .shiftR(shiftR), .i_incr(i_incr),
      .p0(p0), .i_lt_32(i_lt_32), .product(product), .product_valid(product_valid)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: each rising product_valid consumes one expected product.
   always @(negedge CLK or negedge reset_n) begin
      if (product_valid && !vld_prev) begin
         if (exp_q.size() == 0) chk("unexpected_valid", product, 64'hx);
         else chk("final_product", product, exp_q.pop_front());
      end
      vld_prev = product_valid;
   end

   // Shift-add state after k iterations: partial product of the low k multiplier
   // bits sitting in the top, remaining multiplier bits in the bottom.
   function automatic logic [63:0] partial(input logic [31:0] a, input logic [31:0] b, input int k);
      logic [63:0] mask, pp;
      mask = (k >= 32) ? 64'hFFFF_FFFF : ((64'd1 << k) - 64'd1);
      pp   = {32'd0, a} * ({32'd0, b} & mask);
      return (pp << (32 - k)) + ({32'd0, b} >> k);
   endfunction

   task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                          input bit all_strb, input int abort_at);
      mcand = a; mplier = b; i_clr = 1'b1;
      if (all_strb) begin write = 1'b1; shiftR = 1'b1; i_incr = 1'b1; end
      cyc();
      i_clr = 1'b0; write = 1'b0; shiftR = 1'b0; i_incr = 1'b0;
      exp_q.push_back({32'd0, a} * {32'd0, b});
      if (all_strb) begin
         chk("clr_priority_prod", product, {32'd0, b});
         chk("clr_priority_lt", {63'd0, i_lt_32}, 64'd1);
      end
      chk("clr_valid_low", {63'd0, product_valid}, 64'd0);
      for (int it = 0; it < 32; it++) begin
         if (it == abort_at) begin
            #2 reset_n = 1'b0;
            #1;
            chk("midop_rst_prod", product, 64'd0);
            chk("midop_rst_lt", {62'd0, product_valid, i_lt_32}, 64'd1);
            #1 reset_n = 1'b1;
            void'(exp_q.pop_back());
            cyc();
            return;
         end
         chk("p0_vs_mplier_bit", {63'd0, p0}, {63'd0, b[it]});
         chk("i_lt_32", {63'd0, i_lt_32}, {63'd0, (it < 31)});
         if (p0) begin write = 1'b1; cyc(); write = 1'b0; end
         shiftR = 1'b1;
         if ($urandom_range(0, 1) == 1) begin
            i_incr = 1'b1; cyc(); shiftR = 1'b0; i_incr = 1'b0;
         end else begin
            cyc(); shiftR = 1'b0;
            i_incr = 1'b1; cyc(); i_incr = 1'b0;
         end
         chk("iter_state", product, partial(a, b, it + 1));
         if (it < 31) chk("valid_early", {63'd0, product_valid}, 64'd0);
      end
      repeat ($urandom_range(0, 3)) cyc();
      chk("hold_product", product, {32'd0, a} * {32'd0, b});
      chk("hold_valid", {63'd0, product_valid}, 64'd1);
   endtask

   initial begin
      #3;
      chk("reset_prod", product, 64'd0);
      chk("reset_flags", {61'd0, product_valid, p0, i_lt_32}, 64'd1);
      #4 reset_n = 1'b1;
      cyc();
      do_mult(32'd3, 32'd5, 1'b0, -1);
      do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
      do_mult(32'd0, 32'hDEAD_BEEF, 1'b0, -1);
      do_mult(32'h1234_5678, 32'd1, 1'b0, -1);
      // Asynchronous reset mid-cycle with a finished result on the outputs.
      #3 reset_n = 1'b0;
      #1;
      chk("async_rst_prod", product, 64'd0);
      chk("async_rst_flags", {61'd0, product_valid, p0, i_lt_32}, 64'd1);
      #2 reset_n = 1'b1;
      cyc();
      do_mult(32'hCAFE_0001, 32'h8000_0003, 1'b1, -1);
      do_mult($urandom, $urandom, 1'b0, 10);
      do_mult(32'd7, 32'd9, 1'b0, -1);
      for (int n = 0; n < 12; n++) do_mult($urandom, $urandom, n[0], -1);
      done = 1'b1;
   end

   initial begin
      fork
         wait (done);
         begin repeat (20000) @(posedge CLK); end
      join_any
      disable fork;
      if (!done) chk("timeout", 64'd0, 64'd1);
      repeat (2) @(posedge CLK);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
